dmem_slave: RTL and testbench

DMEM_SLAVE -- requirements
Module: dmem_slave

---
 rtl/dmem_pkg.sv | 22 ++
 rtl/dmem_slave_if.sv | 17 +
 rtl/dmem_array.sv | 28 ++
 rtl/dmem_slave.sv | 123 ++++++++++++
 tb/tb_dmem_slave.sv | 189 ++++++++++++++++++
 5 files changed

// File: rtl/dmem_pkg.sv
// Shared types and widths for the dmem_slave data-memory responder.
package dmem_pkg;

  localparam int ADDR_W = 12;
  localparam int DATA_W = 32;
  localparam int BE_W   = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;

  // Word stores must be word aligned, half-word stores half aligned, loads are always full words.
  function automatic logic misaligned_f(input logic we, input logic [1:0] lo, input logic [BE_W-1:0] be);
    if (!we) return (lo != 2'b00);
    if (be == 4'b1111) return (lo != 2'b00);
    if (be == 4'b0011 || be == 4'b1100) return lo[0];
    return 1'b0;
  endfunction

endpackage

// File: rtl/dmem_slave_if.sv
// CPU data-access bus: request fields from the master, one-cycle response from the slave.
interface dmem_slave_if;
  import dmem_pkg::*;

  logic              req;
  logic              we;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic [BE_W-1:0]   be;
  logic              ready;
  logic [DATA_W-1:0] rdata;
  logic              err;

  modport master (output req, we, addr, wdata, be, input ready, rdata, err);
  modport slave  (input req, we, addr, wdata, be, output ready, rdata, err);

endinterface

// File: rtl/dmem_array.sv
// Word storage with per-byte synchronous write and asynchronous word read; never reset.
module dmem_array
  import dmem_pkg::*;
#(
  parameter int unsigned DEPTH = 1024,
  parameter int          IDX_W = 10
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [IDX_W-1:0]  idx,
  input  logic [BE_W-1:0]   be,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int i = 0; i < BE_W; i++) begin
        if (be[i]) mem[idx][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

  assign rdata = mem[idx];

endmodule

// File: rtl/dmem_slave.sv
// Data-memory slave with WAIT_CYCLES wait states and a one-cycle ready strobe.
// Optional alignment checking is enabled by defining DMEM_SLAVE_ALIGN_CHECK_EN.
//   state | meaning
//   IDLE  | waiting for req; accepts and latches the access
//   WAIT  | counting down wait states, req ignored
//   RESP  | ready=1 for one cycle; stores commit on the edge leaving RESP
module dmem_slave
  import dmem_pkg::*;
#(
  parameter int unsigned WAIT_CYCLES = 2,
  parameter int unsigned DEPTH       = 1024
) (
  input logic           clk,
  input logic           rst,
  dmem_slave_if.slave   bus
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  state_e            state, state_nxt;
  logic [3:0]        cnt, cnt_nxt;
  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [BE_W-1:0]   be_q;
  logic [DATA_W-1:0] rdata_q;

  logic              accept, enter_resp, misaligned, wr_en;
  logic              cur_we;
  logic [ADDR_W-1:0] cur_addr;
  logic [BE_W-1:0]   cur_be;
  logic [IDX_W-1:0]  idx;
  logic [DATA_W-1:0] mem_rdata;

  // With zero wait states the response is captured on the accept edge itself,
  // before the latches hold the access, so decode from the live bus while IDLE.
  assign cur_we   = (state == IDLE) ? bus.we   : we_q;
  assign cur_addr = (state == IDLE) ? bus.addr : addr_q;
  assign cur_be   = (state == IDLE) ? bus.be   : be_q;
  assign idx      = IDX_W'(32'(cur_addr[ADDR_W-1:2]) % DEPTH);

  assign accept     = (state == IDLE) && bus.req;
  assign enter_resp = (state_nxt == RESP) && (state != RESP);
  assign wr_en      = (state == RESP) && we_q && !misaligned;

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      IDLE: begin
        if (bus.req) begin
          if (WAIT_CYCLES == 0) begin
            state_nxt = RESP;
            cnt_nxt   = 4'd0;
          end else begin
            state_nxt = WAIT;
            cnt_nxt   = 4'(WAIT_CYCLES);
          end
        end
      end
      WAIT: begin
        if (cnt <= 4'd1) begin
          cnt_nxt   = 4'd0;
          state_nxt = RESP;
        end else begin
          cnt_nxt = cnt - 4'd1;
        end
      end
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= 4'd0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      be_q    <= '0;
      rdata_q <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (accept) begin
        we_q    <= bus.we;
        addr_q  <= bus.addr;
        wdata_q <= bus.wdata;
        be_q    <= bus.be;
      end
      if (enter_resp) rdata_q <= misaligned ? '0 : mem_rdata;
    end
  end

`ifdef DMEM_SLAVE_ALIGN_CHECK_EN
  logic err_q;
  assign misaligned = misaligned_f(cur_we, cur_addr[1:0], cur_be);
  always_ff @(posedge clk or posedge rst) begin
    if (rst)             err_q <= 1'b0;
    else if (enter_resp) err_q <= misaligned;
  end
  assign bus.err = err_q;
`else
  logic unused_align;
  assign misaligned   = 1'b0;
  assign unused_align = ^{cur_addr[1:0], cur_we};
  assign bus.err      = 1'b0;
`endif

  assign bus.ready = (state == RESP);
  assign bus.rdata = rdata_q;

  dmem_array #(.DEPTH(DEPTH), .IDX_W(IDX_W)) u_array (
    .clk   (clk),
    .wr_en (wr_en),
    .idx   (idx),
    .be    (be_q),
    .wdata (wdata_q),
    .rdata (mem_rdata)
  );

endmodule

// File: tb/tb_dmem_slave.sv
// Directed bench: a 2-wait-state instance driven from a vector table, plus a
// zero-wait, 16-word instance for back-to-back and index-wrap sequences.
module tb_dmem_slave;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  dmem_slave_if bus2 ();
  dmem_slave_if bus0 ();

  dmem_slave #(.WAIT_CYCLES(2), .DEPTH(1024)) u_dut2 (.clk(clk), .rst(rst), .bus(bus2));
  dmem_slave #(.WAIT_CYCLES(0), .DEPTH(16))   u_dut0 (.clk(clk), .rst(rst), .bus(bus0));

  typedef struct {
    logic        we;
    logic [11:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic        chk_rd;
    logic [31:0] exp_rd;
    logic        exp_err;
  } vec_t;

  localparam int NVEC = 11;
  vec_t vecs [NVEC];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic access(input bit sel, input logic we, input logic [11:0] addr,
                        input logic [31:0] wdata, input logic [3:0] be,
                        output logic [31:0] rd, output logic er, output int lat);
    bit got;
    @(negedge clk);
    if (sel) begin
      bus0.req = 1'b1; bus0.we = we; bus0.addr = addr; bus0.wdata = wdata; bus0.be = be;
    end else begin
      bus2.req = 1'b1; bus2.we = we; bus2.addr = addr; bus2.wdata = wdata; bus2.be = be;
    end
    @(posedge clk);
    #1;
    if (sel) bus0.req = 1'b0;
    else     bus2.req = 1'b0;
    lat = 0; rd = '0; er = 1'b0; got = 1'b0;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      lat++;
      if (sel ? bus0.ready : bus2.ready) begin
        got = 1'b1;
        rd  = sel ? bus0.rdata : bus2.rdata;
        er  = sel ? bus0.err : bus2.err;
      end
    end
  endtask

  logic [31:0] rd;
  logic        er;
  int          lat;
  int          nready;
  logic [31:0] w010_final;

  initial begin
    bus2.req = 1'b0; bus2.we = 1'b0; bus2.addr = '0; bus2.wdata = '0; bus2.be = '0;
    bus0.req = 1'b0; bus0.we = 1'b0; bus0.addr = '0; bus0.wdata = '0; bus0.be = '0;

    vecs[0]  = '{1'b1, 12'h010, 32'h12345678, 4'b1111, 1'b0, 32'h0,        1'b0};
    vecs[1]  = '{1'b0, 12'h010, 32'h0,        4'b0000, 1'b1, 32'h12345678, 1'b0};
    vecs[2]  = '{1'b1, 12'h010, 32'hAABBCCDD, 4'b0101, 1'b1, 32'h12345678, 1'b0};
    vecs[3]  = '{1'b0, 12'h010, 32'h0,        4'b1111, 1'b1, 32'h12BB56DD, 1'b0};
    vecs[4]  = '{1'b1, 12'h010, 32'hDEADBEEF, 4'b0000, 1'b1, 32'h12BB56DD, 1'b0};
    vecs[5]  = '{1'b0, 12'h010, 32'h0,        4'b0000, 1'b1, 32'h12BB56DD, 1'b0};
`ifdef DMEM_SLAVE_ALIGN_CHECK_EN
    vecs[6]  = '{1'b0, 12'h013, 32'h0,        4'b0000, 1'b1, 32'h00000000, 1'b1};
    vecs[7]  = '{1'b1, 12'h011, 32'h99999999, 4'b0011, 1'b1, 32'h00000000, 1'b1};
    vecs[8]  = '{1'b0, 12'h010, 32'h0,        4'b0000, 1'b1, 32'h12BB56DD, 1'b0};
    w010_final = 32'h12BB56DD;
`else
    vecs[6]  = '{1'b0, 12'h013, 32'h0,        4'b0000, 1'b1, 32'h12BB56DD, 1'b0};
    vecs[7]  = '{1'b1, 12'h011, 32'h99999999, 4'b0011, 1'b1, 32'h12BB56DD, 1'b0};
    vecs[8]  = '{1'b0, 12'h010, 32'h0,        4'b0000, 1'b1, 32'h12BB9999, 1'b0};
    w010_final = 32'h12BB9999;
`endif
    vecs[9]  = '{1'b1, 12'h020, 32'h11112222, 4'b1111, 1'b0, 32'h0,        1'b0};
    vecs[10] = '{1'b0, 12'h020, 32'h0,        4'b0000, 1'b1, 32'h11112222, 1'b0};

    // reset values while rst is held
    #12;
    check("rst_ready2", 32'(bus2.ready), 32'h0);
    check("rst_rdata2", bus2.rdata, 32'h0);
    check("rst_err2",   32'(bus2.err), 32'h0);
    check("rst_ready0", 32'(bus0.ready), 32'h0);
    @(negedge clk);
    rst = 1'b0;

    for (int v = 0; v < NVEC; v++) begin
      access(1'b0, vecs[v].we, vecs[v].addr, vecs[v].wdata, vecs[v].be, rd, er, lat);
      check($sformatf("vec%0d_latency", v), 32'(lat), 32'd3);
      check($sformatf("vec%0d_err", v), 32'(er), 32'(vecs[v].exp_err));
      if (vecs[v].chk_rd) check($sformatf("vec%0d_rdata", v), rd, vecs[v].exp_rd);
    end

    // reset pulsed while a store to 0x020 sits in WAIT
    @(negedge clk);
    bus2.req = 1'b1; bus2.we = 1'b1; bus2.addr = 12'h020; bus2.wdata = 32'h77777777; bus2.be = 4'b1111;
    @(posedge clk);
    #1 bus2.req = 1'b0;
    @(negedge clk);
    check("wait_before_rst_ready", 32'(bus2.ready), 32'h0);
    #2 rst = 1'b1;
    #1;
    check("midrst_ready", 32'(bus2.ready), 32'h0);
    check("midrst_rdata", bus2.rdata, 32'h0);
    check("midrst_err",   32'(bus2.err), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    nready = 0;
    repeat (8) begin
      @(negedge clk);
      if (bus2.ready) nready++;
    end
    check("rst_discard_ready_count", 32'(nready), 32'd0);
    access(1'b0, 1'b0, 12'h020, 32'h0, 4'b0000, rd, er, lat);
    check("rst_discard_old_word", rd, 32'h11112222);

    // req toggled and fields changed during WAIT
    @(negedge clk);
    bus2.req = 1'b1; bus2.we = 1'b0; bus2.addr = 12'h010; bus2.wdata = 32'h0; bus2.be = 4'b0000;
    @(posedge clk);
    #1 bus2.req = 1'b0;
    lat = 0; rd = '0; er = 1'b0; nready = 0;
    for (int i = 0; i < 40 && nready == 0; i++) begin
      @(negedge clk);
      lat++;
      if (bus2.ready) begin
        nready = 1; rd = bus2.rdata; er = bus2.err;
        bus2.req = 1'b0; bus2.we = 1'b0;
      end else begin
        bus2.req = ~bus2.req; bus2.we = 1'b1; bus2.addr = 12'h020;
        bus2.wdata = 32'hFFFFFFFF; bus2.be = 4'b1111;
      end
    end
    check("ignore_latency", 32'(lat), 32'd3);
    check("ignore_rdata", rd, w010_final);
    check("ignore_err", 32'(er), 32'h0);
    access(1'b0, 1'b0, 12'h020, 32'h0, 4'b0000, rd, er, lat);
    check("ignore_no_store", rd, 32'h11112222);

    // zero wait states: seed two words, then back-to-back loads with req held
    access(1'b1, 1'b1, 12'h000, 32'hA0A0A0A0, 4'b1111, rd, er, lat);
    check("w0_store0_latency", 32'(lat), 32'd1);
    access(1'b1, 1'b1, 12'h004, 32'hB1B1B1B1, 4'b1111, rd, er, lat);
    check("w0_store4_latency", 32'(lat), 32'd1);
    @(negedge clk);
    bus0.req = 1'b1; bus0.we = 1'b0; bus0.addr = 12'h000; bus0.be = 4'b0000;
    @(negedge clk);
    check("b2b_ready_a", 32'(bus0.ready), 32'h1);
    check("b2b_rdata_a", bus0.rdata, 32'hA0A0A0A0);
    bus0.addr = 12'h004;
    @(negedge clk);
    check("b2b_gap", 32'(bus0.ready), 32'h0);
    @(negedge clk);
    check("b2b_ready_b", 32'(bus0.ready), 32'h1);
    check("b2b_rdata_b", bus0.rdata, 32'hB1B1B1B1);
    bus0.req = 1'b0;
    @(negedge clk);
    check("b2b_idle", 32'(bus0.ready), 32'h0);

    // word index wraps modulo DEPTH=16: 0x040 aliases word 0
    access(1'b1, 1'b1, 12'h040, 32'hC3C3C3C3, 4'b1111, rd, er, lat);
    check("wrap_store_pre", rd, 32'hA0A0A0A0);
    access(1'b1, 1'b0, 12'h000, 32'h0, 4'b0000, rd, er, lat);
    check("wrap_load0", rd, 32'hC3C3C3C3);
    access(1'b1, 1'b0, 12'h044, 32'h0, 4'b0000, rd, er, lat);
    check("wrap_load44", rd, 32'hB1B1B1B1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
